// File: rtl/hebbian_learning_sequencer.sv
// Hebbian learning sequencer: timed learning windows, epoch counting and byte-serial weight readout.
// Optional saturation detect on streamed entries is enabled by defining HEB_SAT_DETECT_EN.
module hebbian_learning_sequencer #(
  parameter int N             = 7,
  parameter int WINDOW_CYCLES = 16,
  parameter int GAP_CYCLES    = 4,
  parameter int EPOCHS        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N-1:0]        spikes_in,
  input  logic [N*N*16-1:0]   weights_flat,
  output logic                learning_enable,
  output logic [N-1:0]        spikes_out,
  output logic                busy,
  output logic [7:0]          epoch_count,
  output logic                rd_valid,
  output logic [7:0]          rd_data,
  input  logic                rd_ready,
  output logic                done,
  output logic                sat_flag
);

  localparam int NB = 2 * N * N;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEARN,
    S_GAP,
    S_READOUT,
    S_DONE
  } state_t;

  state_t          state, next_state;
  logic [WW-1:0]   win_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [BW-1:0]   bidx;
  logic [BW+2:0]   byte_base;
  logic            accept, last_win, last_gap, last_byte, last_epoch, start_accept;

  assign accept       = rd_valid && rd_ready;
  assign last_win     = (win_cnt == WW'(WINDOW_CYCLES - 1));
  assign last_gap     = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign last_byte    = (bidx == BW'(NB - 1));
  assign last_epoch   = (epoch_count == 8'(EPOCHS - 1));
  assign start_accept = (state == S_IDLE) && start && !abort;

  // Byte b of the stream is simply bits [b*8 +: 8]: entries are little-endian and in k order.
  assign byte_base = {bidx, 3'b000};
  assign rd_data   = rd_valid ? weights_flat[byte_base +: 8] : 8'h00;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_LEARN;
      S_LEARN:   if (last_win) next_state = last_epoch ? S_READOUT : S_GAP;
      S_GAP:     if (last_gap) next_state = S_LEARN;
      S_READOUT: if (accept && last_byte) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // Outputs are registered from next_state so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      win_cnt         <= '0;
      gap_cnt         <= '0;
      bidx            <= '0;
      epoch_count     <= 8'd0;
      learning_enable <= 1'b0;
      spikes_out      <= '0;
      rd_valid        <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state   <= next_state;
      win_cnt <= (state == S_LEARN && next_state == S_LEARN) ? win_cnt + WW'(1) : '0;
      gap_cnt <= (state == S_GAP && next_state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_READOUT && next_state == S_READOUT)
        bidx <= accept ? bidx + BW'(1) : bidx;
      else
        bidx <= '0;
      if (start_accept)
        epoch_count <= 8'd0;
      else if (state == S_LEARN && last_win && !abort)
        epoch_count <= epoch_count + 8'd1;
      learning_enable <= (next_state == S_LEARN);
      spikes_out      <= (next_state == S_LEARN) ? spikes_in : '0;
      rd_valid        <= (next_state == S_READOUT);
      done            <= (next_state == S_DONE);
      busy            <= (next_state != S_IDLE);
    end
  end

`ifdef HEB_SAT_DETECT_EN
  logic [BW+2:0] ent_base;
  logic [15:0]   cur_entry;

  // An entry counts as streamed once its high byte is accepted.
  assign ent_base  = byte_base & ~(BW+3)'(8);
  assign cur_entry = weights_flat[ent_base +: 16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_flag <= 1'b0;
    else if (start_accept)
      sat_flag <= 1'b0;
    else if (state == S_READOUT && accept && !abort && bidx[0] && cur_entry == 16'h7FFF)
      sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
